// File: rtl/exu_mdu.sv
// Iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Latency: XLEN/BPC+1 cycles accept-to-valid; divide-by-zero/overflow return after 1 cycle.
// Backpressure: o_ready only in IDLE; result held in DONE until i_ready; i_flush kills any op.
module exu_mdu #(
    parameter int XLEN  = 32,
    parameter int BPC   = 1,
    parameter int TAG_W = 37
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_func,
    input  logic [XLEN-1:0]  i_src1,
    input  logic [XLEN-1:0]  i_src2,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int ITERS = XLEN / BPC;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITERS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        func;
    logic              neg;     // negate the selected result on completion
    logic [2*XLEN-1:0] acc;     // product accumulator
    logic [2*XLEN-1:0] mcd;     // shifted multiplicand; divisor lives in the low half
    logic [XLEN-1:0]   opa;     // multiplier (shifts right) or dividend becoming quotient (shifts left)
    logic [XLEN-1:0]   rem;     // partial remainder

    logic              s1_signed, s2_signed, s1_neg, s2_neg;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   mag1, mag2, fast_res;

    logic [2*XLEN-1:0] acc_n, mcd_n, prod;
    logic [XLEN-1:0]   opa_n, rem_n, raw, fin;
    logic [XLEN:0]     trial, diff;

    assign o_ready = (state == ST_IDLE);
    assign o_busy  = (state == ST_BUSY);
    assign o_valid = (state == ST_DONE);

    // Decode the incoming op: operand signedness, magnitudes, and divide corner cases.
    always_comb begin
        s1_signed = (i_func != 3'b011) && (i_func != 3'b101) && (i_func != 3'b111);
        s2_signed = s1_signed && (i_func != 3'b010);
        s1_neg    = s1_signed & i_src1[XLEN-1];
        s2_neg    = s2_signed & i_src2[XLEN-1];
        mag1      = s1_neg ? -i_src1 : i_src1;
        mag2      = s2_neg ? -i_src2 : i_src2;
        div_zero  = (i_src2 == '0);
        div_ovf   = s1_signed && (i_src1 == INT_MIN) && (i_src2 == '1);
        fast      = i_func[2] && (div_zero || div_ovf);
        if (i_func[1]) fast_res = div_zero ? i_src1 : '0;
        else           fast_res = div_zero ? '1 : i_src1;
    end

    // One iteration: BPC shift-add multiply steps or BPC restoring divide steps.
    always_comb begin
        acc_n = acc;
        mcd_n = mcd;
        opa_n = opa;
        rem_n = rem;
        trial = '0;
        diff  = '0;
        for (int b = 0; b < BPC; b++) begin
            if (func[2]) begin
                trial = {rem_n, opa_n[XLEN-1]};
                diff  = trial - {1'b0, mcd[XLEN-1:0]};
                opa_n = {opa_n[XLEN-2:0], ~diff[XLEN]};
                rem_n = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
            end else begin
                if (opa_n[0]) acc_n = acc_n + mcd_n;
                mcd_n = mcd_n << 1;
                opa_n = opa_n >> 1;
            end
        end
    end

    // Sign-correct and select the final result from the last iteration's values.
    always_comb begin
        prod = neg ? -acc_n : acc_n;
        raw  = func[1] ? rem_n : opa_n;
        if (func[2])               fin = neg ? -raw : raw;
        else if (func[1:0] == 2'b00) fin = prod[XLEN-1:0];
        else                       fin = prod[2*XLEN-1:XLEN];
    end

    // Control FSM and datapath registers; reset beats flush, flush beats everything else.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            func     <= '0;
            neg      <= 1'b0;
            acc      <= '0;
            mcd      <= '0;
            opa      <= '0;
            rem      <= '0;
            o_result <= '0;
            o_tag    <= '0;
        end else if (i_flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        func  <= i_func;
                        o_tag <= i_tag;
                        neg   <= (i_func[2] && i_func[1]) ? s1_neg : (s1_neg ^ s2_neg);
                        if (fast) begin
                            o_result <= fast_res;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_BUSY;
                            cnt   <= CNT_INIT;
                            acc   <= '0;
                            rem   <= '0;
                            mcd   <= {{XLEN{1'b0}}, (i_func[2] ? mag2 : mag1)};
                            opa   <= i_func[2] ? mag1 : mag2;
                        end
                    end
                end
                ST_BUSY: begin
                    acc <= acc_n;
                    mcd <= mcd_n;
                    opa <= opa_n;
                    rem <= rem_n;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state    <= ST_DONE;
                        o_result <= fin;
                    end
                end
                ST_DONE: begin
                    if (i_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exu_mdu.sv
// Directed + random bench for exu_mdu with a result scoreboard.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected results come from a behavioural RV32M model using native arithmetic.
module tb_exu_mdu;
    localparam int XLEN  = 32;
    localparam int TAG_W = 37;
    localparam int LAT   = 33;

    logic             i_clock = 1'b0;
    logic             i_reset;
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_func;
    logic [XLEN-1:0]  i_src1;
    logic [XLEN-1:0]  i_src2;
    logic [TAG_W-1:0] i_tag;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_result;
    logic [TAG_W-1:0] o_tag;
    logic             o_busy;

    exu_mdu #(.XLEN(XLEN), .BPC(1), .TAG_W(TAG_W)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_func  (i_func),
        .i_src1  (i_src1),
        .i_src2  (i_src2),
        .i_tag   (i_tag),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_result(o_result),
        .o_tag   (o_tag),
        .o_busy  (o_busy)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb64;
        logic [63:0]        ua, ub, p;
        logic [31:0]        m;
        sa   = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        p    = '0;
        m    = '0;
        case (f)
            3'd0: begin p = sa * sb64;         m = p[31:0];  end
            3'd1: begin p = sa * sb64;         m = p[63:32]; end
            3'd2: begin p = sa * $signed(ub);  m = p[63:32]; end
            3'd3: begin p = ua * ub;           m = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) m = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) m = a;
                else m = $signed(a) / $signed(b);
            end
            3'd5: m = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) m = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) m = 32'd0;
                else m = $signed(a) % $signed(b);
            end
            default: m = (b == 32'd0) ? a : a % b;
        endcase
        return m;
    endfunction

    // Present one op for a single cycle and record its expected outcome.
    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t);
        exp_t e;
        @(negedge i_clock);
        chk("accept_ready", {63'd0, o_ready}, 64'd1);
        i_valid = 1'b1; i_func = f; i_src1 = a; i_src2 = b; i_tag = t;
        e.res = model(f, a, b);
        e.tag = t;
        e.lat = (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : LAT;
        sb.push_back(e);
        @(negedge i_clock);
        i_valid = 1'b0; i_func = '0; i_src1 = '0; i_src2 = '0; i_tag = '0;
    endtask

    // Wait for the result, compare against the scoreboard, optionally stall, then hand off.
    task automatic recv(input string name, input int hold);
        exp_t e;
        int   lat;
        logic rdy_seen;
        lat = 1;
        rdy_seen = 1'b0;
        while (!o_valid && lat < 200) begin
            rdy_seen |= o_ready;
            @(negedge i_clock);
            lat++;
        end
        e = sb.pop_front();
        chk({name, "_valid"}, {63'd0, o_valid}, 64'd1);
        chk({name, "_lat"}, 64'(lat), 64'(e.lat));
        chk({name, "_res"}, {32'd0, o_result}, {32'd0, e.res});
        chk({name, "_tag"}, {27'd0, o_tag}, {27'd0, e.tag});
        chk({name, "_rdylow"}, {63'd0, rdy_seen}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge i_clock);
            chk({name, "_holdvld"}, {63'd0, o_valid}, 64'd1);
            chk({name, "_holdres"}, {32'd0, o_result}, {32'd0, e.res});
        end
        i_ready = 1'b1;
        @(negedge i_clock);
        i_ready = 1'b0;
        chk({name, "_postvld"}, {63'd0, o_valid}, 64'd0);
        chk({name, "_postrdy"}, {63'd0, o_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [2:0]  f;
        logic [31:0] a, b;

        i_reset = 1'b1; i_valid = 1'b0; i_func = '0; i_src1 = '0; i_src2 = '0;
        i_tag = '0; i_flush = 1'b0; i_ready = 1'b0;
        repeat (2) @(negedge i_clock);
        chk("rst_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_busy",  {63'd0, o_busy},  64'd0);
        chk("rst_res",   {32'd0, o_result}, 64'd0);
        chk("rst_tag",   {27'd0, o_tag},   64'd0);
        i_reset = 1'b0;

        send(3'd0, 32'd7, 32'hFFFF_FFFD, 37'h15);             recv("mul", 0);
        send(3'd1, 32'h8000_0000, 32'h8000_0000, 37'h1);      recv("mulh", 0);
        send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 37'h2);      recv("mulhu", 0);
        send(3'd2, 32'hFFFF_FFFF, 32'd2, 37'h3);              recv("mulhsu", 0);
        send(3'd4, 32'hFFFF_FFF9, 32'd2, 37'h4);              recv("div", 0);
        send(3'd6, 32'hFFFF_FFF9, 32'd2, 37'h5);              recv("rem", 0);
        send(3'd5, 32'd100, 32'd7, 37'h6);                    recv("divu", 0);
        send(3'd7, 32'd100, 32'd7, 37'h7);                    recv("remu", 0);
        send(3'd4, 32'd5, 32'd0, 37'h8);                      recv("div0", 0);
        send(3'd6, 32'd5, 32'd0, 37'h9);                      recv("rem0", 0);
        send(3'd5, 32'd5, 32'd0, 37'hA);                      recv("divu0", 0);
        send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 37'hB);      recv("divovf", 0);
        send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 37'hC);      recv("removf", 0);
        send(3'd5, 32'd100, 32'd7, 37'h1F_0000_0001);         recv("bp", 10);

        // Flush during the fifth BUSY cycle.
        send(3'd0, 32'd11, 32'd13, 37'h20);
        repeat (4) @(negedge i_clock);
        chk("fb_busy", {63'd0, o_busy}, 64'd1);
        i_flush = 1'b1;
        @(negedge i_clock);
        i_flush = 1'b0;
        void'(sb.pop_front());
        chk("fb_busy_after", {63'd0, o_busy},  64'd0);
        chk("fb_ready",      {63'd0, o_ready}, 64'd1);
        chk("fb_valid",      {63'd0, o_valid}, 64'd0);

        // Flush while DONE with i_ready high.
        send(3'd0, 32'd3, 32'd4, 37'h21);
        n = 0;
        while (!o_valid && n < 200) begin
            @(negedge i_clock);
            n++;
        end
        chk("fd_valid", {63'd0, o_valid}, 64'd1);
        i_ready = 1'b1; i_flush = 1'b1;
        @(negedge i_clock);
        i_ready = 1'b0; i_flush = 1'b0;
        void'(sb.pop_front());
        chk("fd_valid_after", {63'd0, o_valid}, 64'd0);
        chk("fd_ready",       {63'd0, o_ready}, 64'd1);

        send(3'd5, 32'd9, 32'd3, 37'h22);                     recv("post_flush", 0);

        // Reset in the middle of BUSY.
        send(3'd0, 32'd1234, 32'd5678, 37'h2A);
        repeat (4) @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        void'(sb.pop_front());
        chk("mr_ready", {63'd0, o_ready}, 64'd1);
        chk("mr_valid", {63'd0, o_valid}, 64'd0);
        chk("mr_busy",  {63'd0, o_busy},  64'd0);
        chk("mr_res",   {32'd0, o_result}, 64'd0);
        chk("mr_tag",   {27'd0, o_tag},   64'd0);

        // An op offered together with flush must not be taken.
        @(negedge i_clock);
        i_valid = 1'b1; i_flush = 1'b1; i_func = 3'd0; i_src1 = 32'd2; i_src2 = 32'd2;
        @(negedge i_clock);
        i_valid = 1'b0; i_flush = 1'b0; i_src1 = '0; i_src2 = '0;
        chk("vf_ready", {63'd0, o_ready}, 64'd1);
        chk("vf_busy",  {63'd0, o_busy},  64'd0);

        for (int k = 0; k < 10; k++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (k == 3) ? 32'd0 : ((k % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            send(f, a, b, 37'(k + 64));
            recv("rnd", 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exu_mdu.md
# exu_mdu

Iterative RV32M multiply/divide execute unit, parametrised in data width and bits retired per cycle. Sits beside the integer ALU in the execute stage. Accepts one M-extension operation over a valid/ready handshake, runs a shift-add multiplier or a restoring divider for a configurable number of cycles, and returns the result with its writeback tag. Supports pipeline flush and fast-path handling of RISC-V divide corner cases.

## Interface
Parameters:
- XLEN, 32, operand/result width; even, ≥ 8
- BPC, 1, bits retired per iteration; power of two dividing XLEN
- TAG_W, 37, width of pass-through tag (rd[4:0] + pc[31:0] by default)

Ports:
- i_clock  in  1  clock
- i_reset  in  1  reset; synchronous, active-high
- i_valid  in  1  upstream operation valid
- o_ready  out  1  unit can accept an operation
- i_func  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_src1  in  XLEN  rs1 value
- i_src2  in  XLEN  rs2 value
- i_tag  in  TAG_W  opaque tag, returned unchanged
- i_flush  in  1  kill any in-flight or pending operation
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_result  out  XLEN  result
- o_tag  out  TAG_W  tag of the result
- o_busy  out  1  state is BUSY (for hazard/stall logic)

## Operation
- States: IDLE, BUSY, DONE. o_ready = (state == IDLE). o_busy = (state == BUSY). o_valid = (state == DONE).
- Accept: IDLE & i_valid & !i_flush. Latch func, tag, and operand magnitudes. Latch result sign: MUL* from the signedness per func; DIV sign = s1^s2; REM sign = s1.
- Signed operands: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 as signed, rs2 as unsigned; others unsigned.
- Fast path, decided at accept (divide ops only), next state DONE:
  - divisor == 0: quotient = all ones; remainder = dividend (original signed value).
  - signed overflow (DIV/REM, src1 = 1<<(XLEN-1), src2 = all ones): quotient = src1, remainder = 0.
- Otherwise next state BUSY, iteration counter = XLEN/BPC.
- BUSY, multiply: per cycle, add BPC partial products into a 2·XLEN accumulator; shift multiplier right by BPC.
- BUSY, divide: per cycle, BPC restoring steps; each step shifts the remainder left by 1 with the next dividend bit, subtracts the divisor if no borrow, and shifts the quotient bit in.
- Counter decrements each BUSY cycle. At 1 → DONE. On the BUSY→DONE edge, apply sign correction (two's-complement negate if the sign is set). Select the low XLEN bits (MUL), the high XLEN bits (MULH*), the quotient, or the remainder.
- DONE: hold o_result/o_tag stable until i_ready. DONE & i_ready → IDLE. No new accept in the same cycle.
- Flush: any state with i_flush → IDLE next cycle. The result is discarded even if i_ready is high in DONE (flush wins). An operation presented with i_flush is not accepted.
- Reset: state IDLE, counter 0, o_valid 0, o_busy 0, o_ready 1, o_result 0, o_tag 0.

## Timing
- Normal op latency: accept edge T. BUSY for cycles T+1…T+XLEN/BPC. o_valid is first high in cycle T+XLEN/BPC+1 (33 for defaults).
- Fast-path latency: o_valid is high in cycle T+1.
- Throughput: one op per (latency + 1) cycles minimum; the IDLE cycle after handoff is mandatory.
- o_result and o_tag are registered; there is no combinational path from inputs to outputs except none. o_ready depends only on state.
- i_reset mid-BUSY: next cycle is IDLE with all outputs at reset values, and the partial result is lost.

## Test plan
- MUL 7×(-3), tag 0x15 → o_valid exactly 33 cycles after accept, o_result 0xFFFFFFEB, o_tag 0x15; o_ready low throughout.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF, and REM 5/0 → 5, both valid 1 cycle after accept. DIV 0x80000000/-1 → 0x80000000, and REM of the same operands → 0.
- Backpressure: hold i_ready low for 10 cycles in DONE → o_result stable, o_valid high; when i_ready rises → IDLE next cycle, o_ready 1.
- Flush at BUSY cycle 5, and separately in DONE with i_ready=1 → no handoff, IDLE next cycle; the next op (DIVU 9/3) returns 3 with correct latency. Reset mid-BUSY → all outputs at reset values next cycle.
